// File: rtl/lcd_host_controller.sv
// HD44780 host controller in 8-bit write-only mode.
// After power-up it waits, runs a fixed six-byte init sequence and then
// accepts one host byte at a time. Each byte goes out through a
// setup / enable / hold strobe, followed by an execution wait.
module lcd_host_controller #(
    parameter int unsigned T_POWERUP_CYC = 2_000_000,
    parameter int unsigned T_SETUP_CYC   = 4,
    parameter int unsigned T_EN_CYC      = 25,
    parameter int unsigned T_HOLD_CYC    = 4,
    parameter int unsigned T_SHORT_CYC   = 2500,
    parameter int unsigned T_LONG_CYC    = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_valid,
    input  logic       host_rs,
    input  logic [7:0] host_data,
    output logic       host_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam int unsigned T_MAX_A = (T_POWERUP_CYC > T_SETUP_CYC) ? T_POWERUP_CYC : T_SETUP_CYC;
    localparam int unsigned T_MAX_B = (T_EN_CYC > T_HOLD_CYC) ? T_EN_CYC : T_HOLD_CYC;
    localparam int unsigned T_MAX_C = (T_SHORT_CYC > T_LONG_CYC) ? T_SHORT_CYC : T_LONG_CYC;
    localparam int unsigned T_MAX_AB = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned T_MAX = (T_MAX_AB > T_MAX_C) ? T_MAX_AB : T_MAX_C;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);
    localparam logic [2:0] INIT_LEN = 3'd6;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [7:0]       rom_byte;
    logic             cnt_zero;
    logic             is_long;

    // Counter reload value: a timed state of N cycles starts at N-1.
    function automatic logic [CNT_W-1:0] load(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

    // Init sequence ROM: function set, display on, clear, entry mode.
    always_comb begin
        rom_byte = 8'h38;
        unique case (idx_q)
            3'd0, 3'd1, 3'd2: rom_byte = 8'h38;
            3'd3:             rom_byte = 8'h0C;
            3'd4:             rom_byte = 8'h01;
            3'd5:             rom_byte = 8'h06;
            default:          rom_byte = 8'h38;
        endcase
    end

    assign cnt_zero = (cnt_q == '0);
    // Clear display and return home need the long execution wait.
    assign is_long  = !rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03);

    // Next-state, counter and latched bus contents.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rs_d    = rs_q;
        db_d    = db_q;
        done_d  = done_q;
        unique case (state_q)
            S_PWRUP: begin
                if (cnt_zero) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_INIT: begin
                rs_d    = 1'b0;
                db_d    = rom_byte;
                idx_d   = idx_q + 3'd1;
                state_d = S_SETUP;
                cnt_d   = load(T_SETUP_CYC);
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_EN_HI;
                    cnt_d   = load(T_EN_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_EN_HI: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = load(T_HOLD_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_EXEC;
                    cnt_d   = is_long ? load(T_LONG_CYC) : load(T_SHORT_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (cnt_zero) begin
                    cnt_d = '0;
                    if (idx_q < INIT_LEN && !done_q) begin
                        state_d = S_INIT;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (host_valid && ready_q) begin
                    rs_d    = host_rs;
                    db_d    = host_data;
                    state_d = S_SETUP;
                    cnt_d   = load(T_SETUP_CYC);
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = load(T_POWERUP_CYC);
            end
        endcase
        // Strobe and handshake are registered from the next state.
        e_d     = (state_d == S_EN_HI);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset forces a fresh power-up sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWRUP;
            cnt_q   <= load(T_POWERUP_CYC);
            idx_q   <= 3'd0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign host_ready = ready_q;
    assign init_done  = done_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = e_q;
    assign lcd_db     = db_q;

endmodule

// File: tb/tb_lcd_host_controller.sv
// Scoreboard bench for lcd_host_controller with short timing parameters.
// The driver pushes expected bus bytes and busy lengths; a monitor pops
// them when an E pulse or a host_ready return is observed.
module tb_lcd_host_controller;

    localparam int P_PWR   = 20;
    localparam int P_SET   = 2;
    localparam int P_EN    = 3;
    localparam int P_HOLD  = 2;
    localparam int P_SHORT = 10;
    localparam int P_LONG  = 40;
    localparam logic [7:0] ROM [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_valid = 1'b0;
    logic       host_rs = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;

    lcd_host_controller #(
        .T_POWERUP_CYC(P_PWR),
        .T_SETUP_CYC  (P_SET),
        .T_EN_CYC     (P_EN),
        .T_HOLD_CYC   (P_HOLD),
        .T_SHORT_CYC  (P_SHORT),
        .T_LONG_CYC   (P_LONG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host_valid(host_valid),
        .host_rs   (host_rs),
        .host_data (host_data),
        .host_ready(host_ready),
        .init_done (init_done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    logic [8:0] exp_q[$];
    int busy_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int exec_cyc(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? P_LONG : P_SHORT;
    endfunction

    // Cycle (relative to reset release) of the k-th init E rise.
    function automatic int init_rise(input int k);
        int t = P_PWR;
        for (int j = 0; j < k; j++) t += 1 + P_SET + P_EN + P_HOLD + exec_cyc(1'b0, ROM[j]);
        return t + 1 + P_SET;
    endfunction

    function automatic int init_done_cyc();
        int t = P_PWR;
        for (int j = 0; j < 6; j++) t += 1 + P_SET + P_EN + P_HOLD + exec_cyc(1'b0, ROM[j]);
        return t;
    endfunction

    // Monitor: E pulses, busy lengths and init completion.
    initial begin
        logic prev_e, prev_ready, prev_done;
        int e_width, pulse_idx, busy_cnt, rel;
        logic [8:0] cur, exp;
        prev_e = 0; prev_ready = 0; prev_done = 0;
        e_width = 0; pulse_idx = 0; busy_cnt = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_e = 0; prev_ready = 0; prev_done = 0;
                e_width = 0; pulse_idx = 0; busy_cnt = 0;
            end else begin
                rel = cyc - base;
                if (lcd_e && !prev_e) begin
                    cur = {lcd_rs, lcd_db};
                    e_width = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_e_pulse: got rs/db 0x%0h, expected no pulse", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        check("pulse_rs_db", int'(cur), int'(exp));
                    end
                    check("lcd_rw_zero", int'(lcd_rw), 0);
                    if (!init_done && pulse_idx < 6)
                        check("init_rise_cycle", rel, init_rise(pulse_idx));
                    pulse_idx++;
                end else if (lcd_e) begin
                    e_width++;
                    check("bus_stable_e_high", int'({lcd_rs, lcd_db}), int'(cur));
                end else if (prev_e) begin
                    check("e_width", e_width, P_EN);
                end
                if (init_done && !prev_done) begin
                    check("init_done_cycle", rel, init_done_cyc());
                    check("ready_with_done", int'(host_ready), 1);
                    check("init_pulse_count", pulse_idx, 6);
                end
                if (prev_done && !init_done) check("init_done_sticky", 0, 1);
                if (prev_done && !host_ready) busy_cnt++;
                if (prev_done && host_ready && !prev_ready) begin
                    if (busy_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_busy: got %0d busy cycles, expected none", busy_cnt);
                    end else begin
                        check("busy_cycles", busy_cnt, busy_q.pop_front());
                    end
                    check("idle_bus_held", int'({lcd_rs, lcd_db}), int'(cur));
                    check("idle_e_low", int'(lcd_e), 0);
                    busy_cnt = 0;
                end
                prev_e = lcd_e;
                prev_ready = host_ready;
                prev_done = init_done;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!host_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!host_ready) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic push_init();
        for (int j = 0; j < 6; j++) exp_q.push_back({1'b0, ROM[j]});
    endtask

    task automatic write(input logic rs, input logic [7:0] d, input bit glitch);
        wait_ready();
        host_valid = 1'b1;
        host_rs = rs;
        host_data = d;
        exp_q.push_back({rs, d});
        busy_q.push_back(P_SET + P_EN + P_HOLD + exec_cyc(rs, d));
        @(negedge clk);
        host_valid = 1'b0;
        check("ready_low_after_accept", int'(host_ready), 0);
        if (glitch) begin
            repeat ($urandom_range(0, 8)) @(negedge clk);
            if (!host_ready) begin
                host_valid = 1'b1;
                host_rs = ~rs;
                host_data = 8'($urandom);
                @(negedge clk);
                host_valid = 1'b0;
            end
        end
    endtask

    // Stimulus.
    initial begin
        logic       rs;
        logic [7:0] d;
        int         n;
        repeat (3) @(negedge clk);
        check("rst_lcd_e", int'(lcd_e), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_db", int'(lcd_db), 0);
        check("rst_lcd_rw", int'(lcd_rw), 0);
        check("rst_host_ready", int'(host_ready), 0);
        check("rst_init_done", int'(init_done), 0);
        base = cyc;
        push_init();
        rst_n = 1'b1;

        // Requests during init must be ignored.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(3, 10)) @(negedge clk);
            if (!host_ready) begin
                host_valid = 1'b1;
                host_rs = 1'($urandom);
                host_data = 8'($urandom);
                @(negedge clk);
                host_valid = 1'b0;
            end
        end
        wait_ready();

        write(1'b1, 8'h41, 1'b1);
        write(1'b0, 8'h01, 1'b1);
        write(1'b0, 8'h80, 1'b0);
        // Queued adapter traffic, back to back.
        write(1'b0, 8'h01, 1'b0);
        write(1'b1, 8'h48, 1'b0);
        write(1'b1, 8'h49, 1'b0);
        write(1'b0, 8'hC0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            write(rs, d, 1'($urandom));
        end
        wait_ready();

        // Reset in the middle of an E pulse.
        host_valid = 1'b1;
        host_rs = 1'b1;
        host_data = 8'h77;
        exp_q.push_back({1'b1, 8'h77});
        @(negedge clk);
        host_valid = 1'b0;
        n = 0;
        while (!lcd_e && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("e_seen_before_reset", int'(lcd_e), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_lcd_e", int'(lcd_e), 0);
        check("async_rst_host_ready", int'(host_ready), 0);
        check("async_rst_init_done", int'(init_done), 0);
        check("async_rst_lcd_db", int'(lcd_db), 0);
        exp_q.delete();
        busy_q.delete();
        repeat (2) @(negedge clk);
        base = cyc;
        push_init();
        rst_n = 1'b1;
        @(negedge clk);
        wait_ready();
        write(1'b1, 8'h5A, 1'b0);
        write(1'b0, 8'h02, 1'b0);
        wait_ready();
        repeat (2) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        check("busy_queue_empty", busy_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_host_controller.md
LCD_HOST_CONTROLLER -- requirements
Module: lcd_host_controller

Interface
REQ-001 Parameter T_POWERUP_CYC, default 2_000_000, power-on wait in clk cycles (40 ms at 50 MHz).
REQ-002 Parameter T_SETUP_CYC, default 4, RS/DB setup before E rise, cycles.
REQ-003 Parameter T_EN_CYC, default 25, E high pulse width, cycles.
REQ-004 Parameter T_HOLD_CYC, default 4, RS/DB hold after E fall, cycles.
REQ-005 Parameter T_SHORT_CYC, default 2500, execution wait for normal commands and data, cycles.
REQ-006 Parameter T_LONG_CYC, default 100_000, execution wait for clear/home commands, cycles.
REQ-007 clk  in  1  system clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 host_valid  in  1  one-cycle write request from the upstream adapter.
REQ-010 host_rs  in  1  0 = command, 1 = data; sampled with host_valid.
REQ-011 host_data  in  8  byte to write; sampled with host_valid.
REQ-012 host_ready  out  1  high when a host_valid will be accepted.
REQ-013 init_done  out  1  high once the init sequence completes; stays high until reset.
REQ-014 lcd_rs  out  1  HD44780 RS pin.
REQ-015 lcd_rw  out  1  HD44780 RW pin; constant 0 (write-only).
REQ-016 lcd_e  out  1  HD44780 enable strobe.
REQ-017 lcd_db  out  8  HD44780 DB[7:0], 8-bit bus mode.

Function
REQ-018 States: S_PWRUP, S_INIT, S_SETUP, S_EN_HI, S_HOLD, S_EXEC, S_IDLE.
REQ-019 Phase timing: one down-counter, loaded with N-1 on state entry; state exits when counter = 0, so each timed state lasts exactly N cycles.
REQ-020 Counter width: $clog2 of max(all T_* parameters)+1 bits; all parameters are >= 1.
REQ-021 S_PWRUP lasts T_POWERUP_CYC cycles, then goes to S_INIT.
REQ-022 Init ROM, 6 entries, all RS=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06; 3-bit index starts at 0.
REQ-023 S_INIT (1 cycle): latches ROM[index] into the RS/DB register, increments index, goes to S_SETUP.
REQ-024 Write cycle: S_SETUP (lcd_e=0, T_SETUP_CYC) -> S_EN_HI (lcd_e=1, T_EN_CYC) -> S_HOLD (lcd_e=0, T_HOLD_CYC) -> S_EXEC.
REQ-025 lcd_rs/lcd_db hold the latched values, unchanged, from S_SETUP entry through S_EXEC exit.
REQ-026 S_EXEC lasts T_LONG_CYC when latched RS=0 and DB is 0x01, 0x02 or 0x03; otherwise T_SHORT_CYC.
REQ-027 S_EXEC exit: if init index < 6 and init_done=0 -> S_INIT; else -> S_IDLE.
REQ-028 init_done goes to 1 on entry to S_IDLE after the 6th ROM entry; it never returns to 0 except on reset.
REQ-029 host_ready = 1 only in S_IDLE; it is a registered output, not combinational on host_valid.
REQ-030 Accept: host_valid=1 while host_ready=1 latches {host_rs, host_data} at that edge; next cycle state = S_SETUP, host_ready=0.
REQ-031 host_valid while host_ready=0 (including during init) is ignored; no buffering, no error flag.
REQ-032 S_IDLE holds lcd_e=0 and lcd_rs/lcd_db at the last written values.
REQ-033 Busy time per accepted byte = T_SETUP+T_EN+T_HOLD+T_SHORT (or T_LONG) cycles from the cycle after accept to host_ready=1.
REQ-034 lcd_e is never high for more or fewer than T_EN_CYC consecutive cycles.

Reset
REQ-035 Reset values: state S_PWRUP, counter loaded T_POWERUP_CYC-1, index 0, host_ready=0, init_done=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00.
REQ-036 Reset asserted mid-write (any state) forces reset values immediately, including lcd_e=0; after release the full power-up and init sequence repeats.

Verification (params: POWERUP=20, SETUP=2, EN=3, HOLD=2, SHORT=10, LONG=40)
REQ-037 Release reset, no host traffic -> exactly 6 E pulses with DB 0x38,0x38,0x38,0x0C,0x01,0x06 and RS=0; first E rise at cycle 20+1+2; gap after 0x01 is 40 cycles; then init_done=1 and host_ready=1 in the same cycle.
REQ-038 After init, pulse host_valid with rs=1, data=0x41 -> host_ready=0 next cycle; lcd_rs=1, lcd_db=0x41 held; E high 3 cycles; host_ready returns 17 cycles after the accept cycle.
REQ-039 Command rs=0, data=0x01 after init -> host_ready returns 47 cycles after accept (long wait); rs=0, data=0x80 -> 17 cycles.
REQ-040 host_valid pulsed during init and during a busy write -> no extra E pulse, latched RS/DB unchanged.
REQ-041 Assert rst_n low while lcd_e=1 -> lcd_e, host_ready, init_done drop to 0 without waiting for a clock; after release, full init sequence repeats.
REQ-042 Connect to the FIFO-to-LCD adapter and 4 queued entries {0,0x01},{1,0x48},{1,0x49},{0,0xC0} -> 4 E pulses in order with matching RS/DB; no entry lost or duplicated.
